pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage MIPS pipeline.
- Collects stall requests from fetch, decode, execute and memory, and exception/ERET events from the commit stage.
- Drives the 4-bit stall vector and the flush and redirect-PC signals consumed by the IF/postIF and later pipeline registers.
- Tracks AXI instruction fetches still in flight at a flush, and marks their stale responses for discard.

---
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline, with stale-fetch discard tracking.
// Optional perf counters (stall_cycles_o, flush_count_o) are built only with `define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter logic [31:0] EXC_VECTOR      = 32'hBFC00380,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        if_stall_req_i,
  input  logic        id_stall_req_i,
  input  logic        ex_stall_req_i,
  input  logic        mem_stall_req_i,
  input  logic        exception_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        inst_req_fire_i,
  input  logic        inst_rvalid_i,
  output logic [3:0]  stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] new_pc_o,
  output logic        inst_discard_o,
  output logic        busy_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    RUN,
    DISCARD
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] outstanding, outstanding_nxt;
  logic [CNT_W-1:0] discard_cnt, discard_cnt_nxt;
  logic [3:0]       stall_req, stall_raw;

  always_comb begin
    stall_req = '0;
    if (mem_stall_req_i)     stall_req = 4'b1111;
    else if (ex_stall_req_i) stall_req = 4'b0111;
    else if (id_stall_req_i) stall_req = 4'b0011;
    else if (if_stall_req_i) stall_req = 4'b0001;
  end

  // Flush beats every hold so all registers clear; in DISCARD the PC stays parked.
  always_comb begin
    stall_raw = '0;
    if (!exception_i) begin
      stall_raw = stall_req | {3'b000, state == DISCARD};
    end
  end

  always_comb begin
    outstanding_nxt = outstanding;
    unique case ({inst_req_fire_i, inst_rvalid_i})
      2'b10:   if (outstanding != CNT_MAX) outstanding_nxt = outstanding + CNT_ONE;
      2'b01:   if (outstanding != '0)      outstanding_nxt = outstanding - CNT_ONE;
      default: outstanding_nxt = outstanding;
    endcase
  end

  // The discard reload (outstanding - rvalid + fire) is exactly the updated in-flight count.
  always_comb begin
    state_nxt       = state;
    discard_cnt_nxt = discard_cnt;
    unique case (state)
      RUN: begin
        if (exception_i) begin
          discard_cnt_nxt = outstanding_nxt;
          state_nxt       = (outstanding_nxt != '0) ? DISCARD : RUN;
        end
      end
      DISCARD: begin
        if (exception_i) begin
          discard_cnt_nxt = outstanding_nxt;
          state_nxt       = (outstanding_nxt != '0) ? DISCARD : RUN;
        end else if (inst_rvalid_i) begin
          discard_cnt_nxt = discard_cnt - CNT_ONE;
          if (discard_cnt == CNT_ONE) state_nxt = RUN;
        end
      end
      default: begin
        state_nxt       = RUN;
        discard_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= RUN;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      discard_cnt <= discard_cnt_nxt;
    end
  end

  assign stall_o        = reset_i ? stall_raw : '0;
  assign flush_o        = reset_i & exception_i;
  assign redirect_o     = reset_i & exception_i;
  assign new_pc_o       = (reset_i && exception_i) ? (eret_i ? epc_i : EXC_VECTOR) : '0;
  assign inst_discard_o = (state == DISCARD) & inst_rvalid_i;
  assign busy_o         = (state == DISCARD);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_raw != '0) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (exception_i)     flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle model comparison plus directed literal checks.
// Perf counter expectations follow `define HAZARD_PERF_CNT_EN as the RTL does.
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] EXC_VEC = 32'hBFC00380;
  localparam int          MAXO    = 2;

  logic        clk, rst_n;
  logic        if_req, id_req, ex_req, mem_req;
  logic        exc, eret, fire, rv;
  logic [31:0] epc;
  logic [3:0]  stall;
  logic        flush, redirect, discard, busy;
  logic [31:0] new_pc, stall_cycles, flush_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: fetches in flight and stale responses still to drop.
  int          m_out, m_disc, nx_out, nx_disc;
  logic [31:0] m_stall_cnt, m_flush_cnt, nx_stall_cnt, nx_flush_cnt;

  pipe_hazard_ctrl #(
    .EXC_VECTOR     (EXC_VEC),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst_n),
    .if_stall_req_i (if_req),
    .id_stall_req_i (id_req),
    .ex_stall_req_i (ex_req),
    .mem_stall_req_i(mem_req),
    .exception_i    (exc),
    .eret_i         (eret),
    .epc_i          (epc),
    .inst_req_fire_i(fire),
    .inst_rvalid_i  (rv),
    .stall_o        (stall),
    .flush_o        (flush),
    .redirect_o     (redirect),
    .new_pc_o       (new_pc),
    .inst_discard_o (discard),
    .busy_o         (busy),
    .stall_cycles_o (stall_cycles),
    .flush_count_o  (flush_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > MAXO) return MAXO;
    return v;
  endfunction

  // Compare process: expected outputs from the behavioural rules, checked mid-cycle.
  always @(negedge clk) begin : compare
    int          k;
    logic [3:0]  e_stall;
    logic [31:0] e_pc;
    if (!rst_n) begin
      chk("m_stall", {28'd0, stall}, 32'd0);
      chk("m_flush", {31'd0, flush}, 32'd0);
      chk("m_redirect", {31'd0, redirect}, 32'd0);
      chk("m_newpc", new_pc, 32'd0);
      chk("m_discard", {31'd0, discard}, 32'd0);
      chk("m_busy", {31'd0, busy}, 32'd0);
      nx_out = 0; nx_disc = 0; nx_stall_cnt = '0; nx_flush_cnt = '0;
    end else begin
      k = -1;
      if (if_req)  k = 0;
      if (id_req)  k = 1;
      if (ex_req)  k = 2;
      if (mem_req) k = 3;
      e_stall = (k < 0) ? 4'd0 : 4'((1 << (k + 1)) - 1);
      if (m_disc > 0) e_stall[0] = 1'b1;
      if (exc) e_stall = 4'd0;
      e_pc = exc ? (eret ? epc : EXC_VEC) : 32'd0;
      chk("m_stall", {28'd0, stall}, {28'd0, e_stall});
      chk("m_flush", {31'd0, flush}, {31'd0, exc});
      chk("m_redirect", {31'd0, redirect}, {31'd0, exc});
      chk("m_newpc", new_pc, e_pc);
      chk("m_discard", {31'd0, discard}, {31'd0, (m_disc > 0) && rv});
      chk("m_busy", {31'd0, busy}, {31'd0, m_disc > 0});
`ifdef HAZARD_PERF_CNT_EN
      chk("m_stall_cycles", stall_cycles, m_stall_cnt);
      chk("m_flush_count", flush_count, m_flush_cnt);
`else
      chk("m_stall_cycles", stall_cycles, 32'd0);
      chk("m_flush_count", flush_count, 32'd0);
`endif
      if (m_disc > 0) chk("fire_in_discard", {31'd0, fire}, 32'd0);
      nx_out  = clamp(m_out + int'(fire) - int'(rv));
      nx_disc = m_disc;
      if (exc) nx_disc = clamp(m_out - int'(rv) + int'(fire));
      else if (m_disc > 0 && rv) nx_disc = m_disc - 1;
      nx_stall_cnt = m_stall_cnt + ((e_stall != 4'd0) ? 32'd1 : 32'd0);
      nx_flush_cnt = m_flush_cnt + (exc ? 32'd1 : 32'd0);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = 0; m_disc = 0; m_stall_cnt = '0; m_flush_cnt = '0;
    end else begin
      m_out = nx_out; m_disc = nx_disc; m_stall_cnt = nx_stall_cnt; m_flush_cnt = nx_flush_cnt;
    end
  end

  // req is {mem, ex, id, if}
  task automatic drive(input logic [3:0] req, input logic e, input logic er,
                       input logic [31:0] pc, input logic f, input logic r);
    {mem_req, ex_req, id_req, if_req} = req;
    exc = e; eret = er; epc = pc; fire = f; rv = r;
  endtask

  task automatic idle();
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    // Requests held active during reset must not reach the outputs.
    drive(4'b1000, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    #22;
    chk("rst_stall", {28'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_newpc", new_pc, 32'd0);
    tick();
    idle();
    rst_n = 1'b1;
    #1 chk("post_rst_busy", {31'd0, busy}, 32'd0);
    tick();

    // Stall thermometer
    drive(4'b0110, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    #1 chk("stall_id_ex", {28'd0, stall}, 32'h7);
    tick();
    drive(4'b1110, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    #1 chk("stall_mem", {28'd0, stall}, 32'hF);
    tick();
    drive(4'b0010, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    #1 chk("stall_id", {28'd0, stall}, 32'h3);
    tick();
    drive(4'b0001, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    #1 chk("stall_if", {28'd0, stall}, 32'h1);
    tick();

    // Exception beats a mem stall
    drive(4'b1000, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("exc_flush", {31'd0, flush}, 32'd1);
    chk("exc_stall", {28'd0, stall}, 32'd0);
    chk("exc_newpc", new_pc, 32'hBFC00380);
    tick();

    // ERET redirects to EPC for one cycle only
    drive(4'b0000, 1'b1, 1'b1, 32'h8000_1234, 1'b0, 1'b0);
    #1;
    chk("eret_newpc", new_pc, 32'h8000_1234);
    chk("eret_redirect", {31'd0, redirect}, 32'd1);
    tick();
    idle();
    #1 chk("eret_redirect_drop", {31'd0, redirect}, 32'd0);
    tick();

    // Two fetches in flight at an exception: both responses dropped
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0); tick();
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0); tick();
    drive(4'b0000, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    #1 chk("d2_flush", {31'd0, flush}, 32'd1);
    tick();
    idle();
    #1;
    chk("d2_busy", {31'd0, busy}, 32'd1);
    chk("d2_stall", {28'd0, stall}, 32'h1);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #1 chk("d2_discard1", {31'd0, discard}, 32'd1);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #1 chk("d2_discard2", {31'd0, discard}, 32'd1);
    tick();
    idle();
    #1 chk("d2_busy_drop", {31'd0, busy}, 32'd0);
    tick();

    // Exception together with a fire and a response, one already outstanding
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0); tick();
    drive(4'b0000, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    #1 chk("d1_flush", {31'd0, flush}, 32'd1);
    tick();
    idle();
    #1 chk("d1_busy", {31'd0, busy}, 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    chk("d1_flush_count", flush_count, 32'd4);
`endif
    tick();
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #1 chk("d1_discard", {31'd0, discard}, 32'd1);
    tick();
    idle();
    #1 chk("d1_busy_drop", {31'd0, busy}, 32'd0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0); tick();
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #1 chk("d1_keep", {31'd0, discard}, 32'd0);
    tick();

    // Outstanding saturates at 2; an exception in DISCARD with one left reloads to zero
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      tick();
    end
    drive(4'b0000, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0); tick();
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #1 chk("sat_discard", {31'd0, discard}, 32'd1);
    tick();
    drive(4'b0000, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    #1 chk("reload_discard", {31'd0, discard}, 32'd1);
    tick();
    idle();
    #1 chk("reload_busy", {31'd0, busy}, 32'd0);
    tick();

    // Asynchronous reset in the middle of a DISCARD with two pending
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0); tick();
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0); tick();
    drive(4'b0000, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0); tick();
    drive(4'b0010, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #1 chk("ar_pre_discard", {31'd0, discard}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_stall", {28'd0, stall}, 32'd0);
    chk("ar_discard", {31'd0, discard}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_stall_cycles", stall_cycles, 32'd0);
    chk("ar_flush_count", flush_count, 32'd0);
    tick();
    idle();
    rst_n = 1'b1;
    #1 chk("ar_run_busy", {31'd0, busy}, 32'd0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #1 chk("ar_run_discard", {31'd0, discard}, 32'd0);
    tick();
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
